// File: rtl/pc_pkg.sv
// Shared next-PC select encoding and default PC width, used by pc_unit and the control decoder.
// Pure declarations: no latency and no flow control.
package pc_pkg;

  localparam int PC_W_DEF = 16;

  localparam logic [2:0] PC_SEL_SEQ  = 3'b000;
  localparam logic [2:0] PC_SEL_BR   = 3'b001;
  localparam logic [2:0] PC_SEL_JMP  = 3'b010;
  localparam logic [2:0] PC_SEL_CALL = 3'b011;
  localparam logic [2:0] PC_SEL_RET  = 3'b100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: one-cycle push/pop, combinational top-of-stack read, registered ovf/unf pulses.
// No backpressure: a push when full overwrites the oldest entry; a pop when empty is ignored apart from the unf pulse.
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_dat,
  output logic [PC_W-1:0]            pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic            full;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop_dat = mem[ptr - PTR_ONE];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= push && full;
      unf <= pop && empty;
      // When full, ptr already sits on the oldest entry, so a push overwrites it.
      if (push) begin
        ptr <= ptr + PTR_ONE;
        if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[ptr] <= push_dat;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/call/return select and a circular RAS; one-cycle latency, no bypass.
// stall holds pc and the RAS. Optional PC_EXC_EN redirects targets above PC_LIMIT to EXC_VEC and pulses exc.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              IMM_W     = 7,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(16'h0004),
  parameter logic [PC_W-1:0] PC_LIMIT  = PC_W'(16'h7FFF)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   sel,
  input  logic [IMM_W-1:0]             imm,
  input  logic [PC_W-1:0]              alu_out,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              pc_plus1,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         exc
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0] imm_sx;
  logic [PC_W-1:0] nxt;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] ras_dat;
  logic            ras_empty;
  logic            do_push;
  logic            do_pop;

  assign pc_plus1 = pc + PC_ONE;
  assign imm_sx   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    nxt     = pc_plus1;
    do_push = 1'b0;
    do_pop  = 1'b0;
    case (sel)
      PC_SEL_BR:   nxt = pc_plus1 + imm_sx;
      PC_SEL_JMP:  nxt = alu_out;
      PC_SEL_CALL: begin
        nxt     = alu_out;
        do_push = !stall;
      end
      // An empty stack falls back to the ALU target rather than a stale entry.
      PC_SEL_RET:  begin
        nxt    = ras_empty ? alu_out : ras_dat;
        do_pop = !stall;
      end
      default:     nxt = pc_plus1;
    endcase
  end

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (do_push),
    .pop      (do_pop),
    .push_dat (pc_plus1),
    .pop_dat  (ras_dat),
    .empty    (ras_empty),
    .count    (ras_count),
    .ovf      (ras_ovf),
    .unf      (ras_unf)
  );

`ifdef PC_EXC_EN
  logic illegal;
  assign illegal = (nxt > PC_LIMIT);
  assign tgt     = illegal ? EXC_VEC : nxt;

  always_ff @(posedge clk) begin
    if (rst || stall) exc <= 1'b0;
    else              exc <= illegal;
  end
`else
  logic unused_exc_cfg;
  assign unused_exc_cfg = ^{EXC_VEC, PC_LIMIT};
  assign tgt            = nxt;
  assign exc            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)         pc <= RESET_VEC;
    else if (!stall) pc <= tgt;
  end

endmodule
